// File: rtl/bram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port BRAM with fixed read latency.
// Define BRAM_ARB_WB_PRIO_EN for fixed Wishbone priority; default is round-robin.
module bram_arbiter #(
  parameter int          LAT  = 10,
  parameter logic [7:0]  BASE = 8'h38
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  input  logic        eng_req_i,
  input  logic        eng_we_i,
  input  logic [3:0]  eng_sel_i,
  input  logic [31:0] eng_adr_i,
  input  logic [31:0] eng_dat_i,
  output logic        eng_gnt_o,
  output logic        eng_rvalid_o,
  output logic [31:0] eng_rdata_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_a_o,
  output logic [31:0] bram_di_o,
  input  logic [31:0] bram_do_i,
  output logic        busy_o
);

  localparam int              CW       = $clog2(LAT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(LAT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          owner_eng_reg;
  logic          we_reg;
  logic [3:0]    sel_reg;
  logic [31:0]   adr_reg;
  logic [31:0]   dat_reg;
  logic [31:0]   resp_reg;
  logic          wb_drop_reg;

  logic wb_req;
  logic grant_wb;
  logic grant_eng;
  logic in_idle;
  logic in_access;
  logic in_resp;

  assign wb_req    = wb_cyc_i & wb_stb_i & (wb_adr_i[31:24] == BASE);
  assign in_idle   = (state_reg == S_IDLE);
  assign in_access = (state_reg == S_ACCESS);
  assign in_resp   = (state_reg == S_RESP);

`ifdef BRAM_ARB_WB_PRIO_EN
  assign grant_wb = wb_req;
`else
  // last_eng_reg=1 means the engine was served last, so WB wins the next tie.
  logic last_eng_reg;

  always_ff @(posedge clk) begin
    if (rst)
      last_eng_reg <= 1'b1;
    else if (in_idle && (wb_req || eng_req_i))
      last_eng_reg <= ~grant_wb;
  end

  assign grant_wb = wb_req & (~eng_req_i | last_eng_reg);
`endif

  assign grant_eng = eng_req_i & ~grant_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      owner_eng_reg <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= 4'h0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      resp_reg      <= '0;
      wb_drop_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_wb || grant_eng) begin
            owner_eng_reg <= grant_eng;
            we_reg        <= grant_eng ? eng_we_i  : wb_we_i;
            sel_reg       <= grant_eng ? eng_sel_i : wb_sel_i;
            adr_reg       <= grant_eng ? eng_adr_i : wb_adr_i;
            dat_reg       <= grant_eng ? eng_dat_i : wb_dat_i;
            cnt_reg       <= '0;
            wb_drop_reg   <= 1'b0;
            state_reg     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt_reg <= cnt_reg + CW'(1);
          // An abandoned WB cycle still finishes on the BRAM but gets no ack.
          if (!owner_eng_reg && !(wb_cyc_i && wb_stb_i))
            wb_drop_reg <= 1'b1;
          if (cnt_reg == CNT_LAST) begin
            resp_reg  <= we_reg ? 32'h0 : bram_do_i;
            state_reg <= S_RESP;
          end
        end
        S_RESP:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = ~in_idle;
  assign bram_en_o    = in_access;
  assign bram_we_o    = (in_access && (cnt_reg == '0) && we_reg) ? sel_reg : 4'h0;
  assign bram_a_o     = in_access ? adr_reg : 32'h0;
  assign bram_di_o    = in_access ? dat_reg : 32'h0;
  assign eng_gnt_o    = ~rst & in_idle & grant_eng;
  assign wb_ack_o     = in_resp & ~owner_eng_reg & ~wb_drop_reg;
  assign wb_dat_o     = wb_ack_o ? resp_reg : 32'h0;
  assign eng_rvalid_o = in_resp & owner_eng_reg;
  assign eng_rdata_o  = eng_rvalid_o ? resp_reg : 32'h0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: random WB/engine traffic against a memory
// model that predicts arbitration order, completion cycle and read data.
`timescale 1ns/1ps
module tb_bram_arbiter;

  localparam int         LAT  = 10;
  localparam logic [7:0] BASE = 8'h38;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'h0;
  logic [31:0] wb_adr = '0, wb_dat = '0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        eng_req = 1'b0, eng_we = 1'b0;
  logic [3:0]  eng_sel = 4'h0;
  logic [31:0] eng_adr = '0, eng_dat = '0;
  logic        eng_gnt_o, eng_rvalid_o;
  logic [31:0] eng_rdata_o;
  logic        bram_en_o;
  logic [3:0]  bram_we_o;
  logic [31:0] bram_a_o, bram_di_o;
  logic [31:0] bram_do = '0;
  logic        busy_o;

  bram_arbiter #(.LAT(LAT), .BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .eng_req_i(eng_req), .eng_we_i(eng_we), .eng_sel_i(eng_sel), .eng_adr_i(eng_adr),
    .eng_dat_i(eng_dat), .eng_gnt_o(eng_gnt_o), .eng_rvalid_o(eng_rvalid_o),
    .eng_rdata_o(eng_rdata_o), .bram_en_o(bram_en_o), .bram_we_o(bram_we_o),
    .bram_a_o(bram_a_o), .bram_di_o(bram_di_o), .bram_do_i(bram_do), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // BRAM device: word-indexed by byte address bits [11:2], registered read.
  logic [31:0] bram_mem [0:1023];
  always @(posedge clk) begin
    if (bram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bram_we_o[b]) bram_mem[bram_a_o[11:2]][8*b +: 8] <= bram_di_o[8*b +: 8];
      bram_do <= bram_mem[bram_a_o[11:2]];
    end
  end

  // Reference model state.
  typedef struct { bit eng; logic [31:0] data; int unsigned due; } exp_t;
  logic [31:0] ref_mem [0:1023];
  exp_t        sb[$];
  exp_t        mon_e;
  bit          m_last_eng = 1'b1;
  int          exp_writes = 0;
  int          we_cycles  = 0;
  int unsigned wb_acks = 0, eng_rvs = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic model_op(input bit eng, input bit we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat, input int unsigned due);
    exp_t e;
    logic [31:0] w;
    w = ref_mem[adr[11:2]];
    if (we) begin
      for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
      ref_mem[adr[11:2]] = w;
      e.data = 32'h0;
      if (sel != 4'h0) exp_writes++;
    end else begin
      e.data = w;
    end
    e.eng = eng;
    e.due = due;
    sb.push_back(e);
    m_last_eng = eng;
  endtask

  // Monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_we_o != 4'h0) we_cycles++;
      if (wb_ack_o) wb_acks++;
      if (eng_rvalid_o) eng_rvs++;
      if (wb_ack_o || eng_rvalid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 32'({wb_ack_o, eng_rvalid_o}), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("eng_rvalid", 32'(eng_rvalid_o), 32'(mon_e.eng));
          check("wb_ack", 32'(wb_ack_o), 32'(!mon_e.eng));
          check("rdata", mon_e.eng ? eng_rdata_o : wb_dat_o, mon_e.data);
          check("done_cycle", cyc_cnt, mon_e.due);
          $display("[TB] txn %s data=%h cycle=%0d", mon_e.eng ? "ENG" : "WB ",
                   mon_e.eng ? eng_rdata_o : wb_dat_o, cyc_cnt);
        end
      end else begin
        check("idle_data_zero", wb_dat_o | eng_rdata_o, 32'h0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy_o; i++) @(negedge clk);
    check("idle_wait", 32'(busy_o), 32'h0);
  endtask

  task automatic wb_finish();
    bit got = 1'b0;
    for (int i = 0; i < 3*LAT + 10; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin got = 1'b1; break; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check("wb_ack_seen", 32'(got), 32'h1);
  endtask

  task automatic eng_finish(input int unsigned gnt_due);
    bit got = 1'b0;
    int unsigned at = 0;
    for (int i = 0; i < 3*LAT + 10; i++) begin
      #1;
      if (eng_gnt_o) begin got = 1'b1; at = cyc_cnt; break; end
      @(negedge clk);
    end
    @(negedge clk);
    eng_req = 1'b0;
    check("eng_gnt_seen", 32'(got), 32'h1);
    if (got) check("eng_gnt_cycle", at, gnt_due);
  endtask

  task automatic drive_wb(input bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat = dat;
  endtask

  task automatic drive_eng(input bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    eng_req = 1'b1; eng_we = we; eng_sel = sel; eng_adr = adr; eng_dat = dat;
  endtask

  task automatic do_wb(input bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    wait_idle();
    model_op(1'b0, we, sel, adr, dat, cyc_cnt + LAT + 1);
    drive_wb(we, sel, adr, dat);
    wb_finish();
  endtask

  task automatic do_eng(input bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    int unsigned k;
    wait_idle();
    k = cyc_cnt;
    model_op(1'b1, we, sel, adr, dat, k + LAT + 1);
    drive_eng(we, sel, adr, dat);
    eng_finish(k);
  endtask

  task automatic do_pair(input bit wwe, input logic [3:0] wsel, input logic [31:0] wadr, input logic [31:0] wdat,
                         input bit ewe, input logic [3:0] esel, input logic [31:0] eadr, input logic [31:0] edat);
    int unsigned k, g;
    bit wb_first;
    wait_idle();
    k = cyc_cnt;
`ifdef BRAM_ARB_WB_PRIO_EN
    wb_first = 1'b1;
`else
    wb_first = m_last_eng;
`endif
    if (wb_first) begin
      model_op(1'b0, wwe, wsel, wadr, wdat, k + LAT + 1);
      model_op(1'b1, ewe, esel, eadr, edat, k + 2*LAT + 3);
      g = k + LAT + 2;
    end else begin
      model_op(1'b1, ewe, esel, eadr, edat, k + LAT + 1);
      model_op(1'b0, wwe, wsel, wadr, wdat, k + 2*LAT + 3);
      g = k;
    end
    drive_wb(wwe, wsel, wadr, wdat);
    drive_eng(ewe, esel, eadr, edat);
    fork
      wb_finish();
      eng_finish(g);
    join
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, acks0;
    bit bad;
    for (int i = 0; i < 1024; i++) begin bram_mem[i] = '0; ref_mem[i] = '0; end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_en", 32'({bram_en_o, bram_we_o}), 32'h0);
    check("rst_done", 32'({wb_ack_o, eng_rvalid_o, eng_gnt_o}), 32'h0);
    check("rst_bus", bram_a_o | bram_di_o | wb_dat_o | eng_rdata_o, 32'h0);
    rst = 1'b0;
    m_last_eng = 1'b1;

    // Simultaneous requests from reset.
    for (int r = 0; r < 4; r++)
      do_pair(1'b1, 4'hF, 32'h3800_0040 + 32'(r*4), 32'hA000_0000 + 32'(r),
              1'b0, 4'hF, 32'h0000_0040 + 32'(r*4), 32'h0);

    // Basic write/read and cross-requester read.
    do_wb(1'b1, 4'hF, 32'h3800_0004, 32'hDEAD_BEEF);
    do_wb(1'b0, 4'hF, 32'h3800_0004, 32'h0);
    do_eng(1'b0, 4'hF, 32'h0000_0004, 32'h0);

    // Byte-lane write.
    do_wb(1'b1, 4'hF, 32'h3800_0010, 32'h1122_3344);
    do_wb(1'b1, 4'b0010, 32'h3800_0010, 32'h0000_AB00);
    do_wb(1'b0, 4'hF, 32'h3800_0010, 32'h0);

    // Non-decoding address is ignored.
    wait_idle();
    drive_wb(1'b0, 4'hF, 32'h3000_0000, 32'h0);
    bad = 1'b0;
    acks0 = wb_acks;
    repeat (20) begin
      @(negedge clk);
      if (bram_en_o || busy_o) bad = 1'b1;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check("nodecode_quiet", 32'(bad), 32'h0);
    check("nodecode_no_ack", wb_acks, acks0);

    // WB drops stb mid-access: access completes silently.
    wait_idle();
    drive_wb(1'b0, 4'hF, 32'h3800_0004, 32'h0);
    m_last_eng = 1'b0;
    repeat (3) @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    acks0 = wb_acks;
    repeat (15) @(negedge clk);
    check("drop_no_ack", wb_acks, acks0);
    check("drop_idle", 32'(busy_o), 32'h0);

    // Reset during ACCESS cnt=5 of a WB read.
    wait_idle();
    k = cyc_cnt;
    drive_wb(1'b0, 4'hF, 32'h3800_0004, 32'h0);
    repeat (6) @(negedge clk);
    check("mid_access_en", 32'(bram_en_o), 32'h1);
    rst = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy_o), 32'h0);
    check("mid_rst_en", 32'(bram_en_o), 32'h0);
    check("mid_rst_done", 32'({wb_ack_o, eng_rvalid_o}), 32'h0);
    rst = 1'b0;
    m_last_eng = 1'b1;
    acks0 = wb_acks + eng_rvs;
    repeat (15) @(negedge clk);
    check("mid_rst_no_ack", wb_acks + eng_rvs, acks0);

    // Random mixed traffic.
    for (int t = 0; t < 40; t++) begin
      int unsigned mode, widx, eidx;
      mode = $urandom_range(0, 2);
      widx = $urandom_range(0, 7);
      eidx = $urandom_range(0, 7);
      case (mode)
        0: do_wb(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                 32'h3800_0100 + 32'(widx*4), $urandom);
        1: do_eng(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                  32'h0000_0100 + 32'(eidx*4), $urandom);
        default: do_pair(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                         32'h3800_0100 + 32'(widx*4), $urandom,
                         1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                         32'h0000_0100 + 32'(eidx*4), $urandom);
      endcase
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    check("we_pulse_cycles", 32'(we_cycles), 32'(exp_writes));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
